// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: result packet, source indices and the
// round-robin helper.
`ifndef CDB_NUM_SRC
`define CDB_NUM_SRC 4
`endif

package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC = `CDB_NUM_SRC;

  typedef enum logic [1:0] {
    CDB_SRC_ALU  = 2'd0,
    CDB_SRC_ST   = 2'd1,
    CDB_SRC_MULT = 2'd2,
    CDB_SRC_LD   = 2'd3
  } cdb_src_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] value;
    logic [4:0]  rob_tag;
  } EX_WR_PACKET;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bus bundle between the functional units / RS and the CDB arbiter.
// With CDB_ARB_PERF_EN defined it also carries the per-source conflict counters.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
  parameter int NUM_SRC = CDB_NUM_SRC
) ();

  logic                                squash;
  EX_WR_PACKET [NUM_SRC-1:0]           src_packet;
  logic        [NUM_SRC-1:0]           src_stall;
  EX_WR_PACKET                         cdb_packet;
  logic        [$clog2(NUM_SRC)-1:0]   cdb_src;
`ifdef CDB_ARB_PERF_EN
  logic        [NUM_SRC-1:0][31:0]     conflict_cnt;

  modport master (output squash, src_packet,
                  input  src_stall, cdb_packet, cdb_src, conflict_cnt);
  modport slave  (input  squash, src_packet,
                  output src_stall, cdb_packet, cdb_src, conflict_cnt);
`else
  modport master (output squash, src_packet,
                  input  src_stall, cdb_packet, cdb_src);
  modport slave  (input  squash, src_packet,
                  output src_stall, cdb_packet, cdb_src);
`endif

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO. A write into a full FIFO is accepted when the head
// is popped in the same cycle; flush empties it without touching storage.
module cdb_src_fifo import cdb_arbiter_pkg::*; #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        wr_en,
  input  EX_WR_PACKET wr_data,
  input  logic        rd_en,
  output EX_WR_PACKET rd_data,
  output logic        empty,
  output logic        full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  EX_WR_PACKET      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_rd;
  logic             do_wr;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB among the functional-unit result FIFOs.
// Optional per-source conflict counters are built when CDB_ARB_PERF_EN is defined.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  cdb_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_SRC);

  EX_WR_PACKET [NUM_SRC-1:0] head;
  logic        [NUM_SRC-1:0] empty;
  logic        [NUM_SRC-1:0] full;
  logic        [NUM_SRC-1:0] pop;
  logic        [IDX_W-1:0]   rr_ptr;
  logic        [IDX_W-1:0]   win;
  logic                      has_win;
  EX_WR_PACKET               cdb_packet_p1;
  logic        [IDX_W-1:0]   cdb_src_p1;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cdb_src_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush   (bus.squash),
      .wr_en   (bus.src_packet[g].valid),
      .wr_data (bus.src_packet[g]),
      .rd_en   (pop[g]),
      .rd_data (head[g]),
      .empty   (empty[g]),
      .full    (full[g])
    );

    assign pop[g] = has_win && (win == IDX_W'(g));

    a_no_drop : assert property (@(posedge clock) disable iff (reset || bus.squash)
      !(bus.src_packet[g].valid && full[g] && !pop[g]));
  end

  // Stall comes straight from FIFO occupancy registers.
  assign bus.src_stall = full;

  // Scan from the farthest offset down so the nearest candidate to rr_ptr wins.
  always_comb begin
    has_win = 1'b0;
    win     = rr_ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (!empty[(int'(rr_ptr) + k) % NUM_SRC]) begin
        has_win = 1'b1;
        win     = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  // ---- stage p1: registered CDB broadcast ----
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_packet_p1 <= '0;
      cdb_src_p1    <= '0;
      rr_ptr        <= '0;
    end else if (bus.squash || !has_win) begin
      cdb_packet_p1 <= '0;
    end else begin
      cdb_packet_p1       <= head[win];
      cdb_packet_p1.valid <= 1'b1;
      cdb_src_p1          <= win;
      rr_ptr              <= IDX_W'(rr_next(int'(win), NUM_SRC));
    end
  end

  assign bus.cdb_packet = cdb_packet_p1;
  assign bus.cdb_src    = cdb_src_p1;

`ifdef CDB_ARB_PERF_EN
  logic [NUM_SRC-1:0][31:0] conflict_cnt;

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reset) begin
        conflict_cnt[i] <= '0;
      end else if (!empty[i] && !(has_win && win == IDX_W'(i))
                   && conflict_cnt[i] != 32'hFFFF_FFFF) begin
        conflict_cnt[i] <= conflict_cnt[i] + 32'd1;
      end
    end
  end

  assign bus.conflict_cnt = conflict_cnt;
`endif

endmodule
